// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter
//   Arbitrates two requesters (m0, m1) onto one downstream DMA port. All
//   handshakes use the toggle protocol: a side has work pending while its
//   req differs from the matching ack. Only one downstream transaction is
//   outstanding at a time. Ties are broken round-robin.
//
// Ports
//   clk, reset                 system clock, asynchronous active-low reset
//   mN_a/mN_d/mN_rw            requester address, write data, direction (1 = read)
//   mN_req / mN_ack            requester toggle request / acknowledge
//   mN_q                       read data returned to requester N
//   mN_lock                    hold-bus request (only with DMA_ARB_LOCK_EN)
//   dma_a/dma_d/dma_rw/dma_req downstream request fields and toggle
//   dma_q / dma_ack            downstream read data and toggle acknowledge
//
// Build option
//   DMA_ARB_LOCK_EN  adds m0_lock/m1_lock; a completion with its lock high
//                    reserves the next grant for the same requester.
//
// state | meaning
// ------+----------------------------------------------------------
// SYNC  | after reset, align dma_req to dma_ack
// IDLE  | look for pending requesters, pick the winner
// ISSUE | capture the winner's fields, toggle dma_req
// WAIT  | wait for dma_ack == dma_req, return data, toggle winner ack

module dma_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] m0_a,
    input  logic [7:0]  m0_d,
    input  logic        m0_rw,
    input  logic        m0_req,
    output logic        m0_ack,
    output logic [7:0]  m0_q,
    input  logic [15:0] m1_a,
    input  logic [7:0]  m1_d,
    input  logic        m1_rw,
    input  logic        m1_req,
    output logic        m1_ack,
    output logic [7:0]  m1_q,
`ifdef DMA_ARB_LOCK_EN
    input  logic        m0_lock,
    input  logic        m1_lock,
`endif
    output logic [15:0] dma_a,
    output logic [7:0]  dma_d,
    output logic        dma_rw,
    output logic        dma_req,
    input  logic [7:0]  dma_q,
    input  logic        dma_ack
);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0] state;
    logic       winner;
    logic       last_gnt;
    logic [1:0] pend;
    logic [1:0] pend_eff;
    logic       gnt_idx;

`ifdef DMA_ARB_LOCK_EN
    logic       lock_active;
    logic       lock_owner;
`endif

    // A requester that re-toggles before its ack simply cancels its own
    // pending state (req == ack again); it never queues a second request.
    assign pend = {m1_req ^ m1_ack, m0_req ^ m0_ack};

    always_comb begin
        pend_eff = pend;
`ifdef DMA_ARB_LOCK_EN
        // While locked, only the owner may be granted; the other keeps its
        // pending toggle and is served once the lock is released.
        if (lock_active) begin
            pend_eff = lock_owner ? {pend[1], 1'b0} : {1'b0, pend[0]};
        end
`endif
        gnt_idx = 1'b0;
        unique case (pend_eff)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_gnt;
            default: gnt_idx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_SYNC;
            winner   <= 1'b0;
            last_gnt <= 1'b1;
            dma_a    <= 16'h0000;
            dma_d    <= 8'h00;
            dma_rw   <= 1'b1;
            dma_req  <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_q     <= 8'h00;
            m1_q     <= 8'h00;
`ifdef DMA_ARB_LOCK_EN
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_SYNC: begin
                    dma_req <= dma_ack;
                    state   <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (|pend_eff) begin
                        winner <= gnt_idx;
                        state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dma_a   <= winner ? m1_a  : m0_a;
                    dma_d   <= winner ? m1_d  : m0_d;
                    dma_rw  <= winner ? m1_rw : m0_rw;
                    dma_req <= ~dma_req;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (dma_ack == dma_req) begin
                        if (winner) begin
                            if (dma_rw) m1_q <= dma_q;
                            m1_ack <= ~m1_ack;
                        end else begin
                            if (dma_rw) m0_q <= dma_q;
                            m0_ack <= ~m0_ack;
                        end
                        last_gnt <= winner;
`ifdef DMA_ARB_LOCK_EN
                        lock_active <= winner ? m1_lock : m0_lock;
                        lock_owner  <= winner;
`endif
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
module tb_dma_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] m0_a, m1_a;
    logic [7:0]  m0_d, m1_d;
    logic        m0_rw, m1_rw;
    logic        m0_req, m1_req;
    logic        m0_ack, m1_ack;
    logic [7:0]  m0_q, m1_q;
`ifdef DMA_ARB_LOCK_EN
    logic        m0_lock, m1_lock;
`endif
    logic [15:0] dma_a;
    logic [7:0]  dma_d;
    logic        dma_rw;
    logic        dma_req;
    logic [7:0]  dma_q;
    logic        dma_ack;

    int checks = 0;
    int failures = 0;

    // downstream responder controls
    bit       resp_en = 0;
    int       resp_delay = 0;
    logic [7:0] resp_q = 8'h00;

    // completion log: 0 = m0_ack toggled, 1 = m1_ack toggled
    int  ack_log[$];
    logic p0 = 1'b0, p1 = 1'b0;

    dma_bus_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .m0_a    (m0_a),
        .m0_d    (m0_d),
        .m0_rw   (m0_rw),
        .m0_req  (m0_req),
        .m0_ack  (m0_ack),
        .m0_q    (m0_q),
        .m1_a    (m1_a),
        .m1_d    (m1_d),
        .m1_rw   (m1_rw),
        .m1_req  (m1_req),
        .m1_ack  (m1_ack),
        .m1_q    (m1_q),
`ifdef DMA_ARB_LOCK_EN
        .m0_lock (m0_lock),
        .m1_lock (m1_lock),
`endif
        .dma_a   (dma_a),
        .dma_d   (dma_d),
        .dma_rw  (dma_rw),
        .dma_req (dma_req),
        .dma_q   (dma_q),
        .dma_ack (dma_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream model: answers resp_delay negedges after seeing a new toggle.
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (resp_en && reset && (dma_req !== dma_ack)) begin
                if (cnt >= resp_delay) begin
                    dma_q   = resp_q;
                    dma_ack = dma_req;
                    cnt     = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            if (m0_ack !== p0) ack_log.push_back(0);
            if (m1_ack !== p1) ack_log.push_back(1);
        end
        p0 = m0_ack;
        p1 = m1_ack;
    end

    task automatic wait_log(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (ack_log.size() >= n) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (dma_a !== 16'h0000) begin failures++; $display("FAIL rst_dma_a got=%h exp=0000", dma_a); end
        checks++; if (dma_d !== 8'h00) begin failures++; $display("FAIL rst_dma_d got=%h exp=00", dma_d); end
        checks++; if (dma_rw !== 1'b1) begin failures++; $display("FAIL rst_dma_rw got=%b exp=1", dma_rw); end
        checks++; if (dma_req !== 1'b0) begin failures++; $display("FAIL rst_dma_req got=%b exp=0", dma_req); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks got=%b%b exp=00", m0_ack, m1_ack); end
        checks++; if ({m0_q, m1_q} !== 16'h0000) begin failures++; $display("FAIL rst_q got=%h/%h exp=00/00", m0_q, m1_q); end
        dma_ack = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (dma_req !== 1'b1) begin failures++; $display("FAIL sync_dma_req got=%b exp=1", dma_req); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (dma_req !== 1'b1 || ack_log.size() != 0) begin
            failures++; $display("FAIL sync_quiet dma_req=%b exp=1 log=%0d exp=0", dma_req, ack_log.size());
        end
        resp_en = 1;
    endtask

    task automatic test_round_robin;
        int  base;
        bit  ok;
        base = ack_log.size();
        resp_delay = 0;
        resp_q = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m0_a = 16'h1000 + 16'(i); m0_rw = 1'b1;
            m1_a = 16'h2000 + 16'(i); m1_rw = 1'b1;
            m0_req = ~m0_req;
            m1_req = ~m1_req;
            wait_log(base + 2 * (i + 1), ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_timeout iter=%0d log=%0d exp=%0d", i, ack_log.size(), base + 2 * (i + 1)); end
        end
        repeat (4) @(posedge clk);
        #2;
        checks++; if (ack_log.size() != base + 8) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", ack_log.size() - base, 8); end
        for (int k = 0; k < 8 && base + k < ack_log.size(); k++) begin
            checks++; if (ack_log[base + k] != (k % 2)) begin
                failures++; $display("FAIL rr_order slot=%0d got=m%0d exp=m%0d", k, ack_log[base + k], k % 2);
            end
        end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL rr_acks got=%b%b exp=00", m0_ack, m1_ack); end
        checks++; if (m0_q !== 8'h5A || m1_q !== 8'h5A) begin failures++; $display("FAIL rr_q got=%h/%h exp=5a/5a", m0_q, m1_q); end
    endtask

    task automatic test_read;
        int base;
        bit ok;
        base = ack_log.size();
        resp_delay = 2;
        resp_q = 8'h0E;
        @(negedge clk);
        m0_a = 16'hD020; m0_rw = 1'b1; m0_d = 8'h99;
        m0_req = ~m0_req;
        wait_log(base + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rd_timeout log=%0d exp=%0d", ack_log.size(), base + 1); end
        checks++; if (dma_a !== 16'hD020) begin failures++; $display("FAIL rd_dma_a got=%h exp=d020", dma_a); end
        checks++; if (dma_rw !== 1'b1) begin failures++; $display("FAIL rd_dma_rw got=%b exp=1", dma_rw); end
        checks++; if (m0_q !== 8'h0E) begin failures++; $display("FAIL rd_m0_q got=%h exp=0e", m0_q); end
        checks++; if (m0_ack !== 1'b1) begin failures++; $display("FAIL rd_m0_ack got=%b exp=1", m0_ack); end
        repeat (5) @(posedge clk);
        #2;
        checks++; if (ack_log.size() != base + 1 || ack_log[base] != 0) begin
            failures++; $display("FAIL rd_once log=%0d exp=%0d", ack_log.size() - base, 1);
        end
    endtask

    task automatic test_latency;
        int   lat;
        logic prev;
        lat = 0;
        resp_delay = 0;
        @(negedge clk);
        prev = m0_ack;
        m0_a = 16'h1234;
        m0_req = ~m0_req;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (lat == 0 && m0_ack !== prev) lat = i;
        end
        checks++; if (lat != 3) begin failures++; $display("FAIL min_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_write_stable;
        int base;
        bit ok;
        base = ack_log.size();
        resp_delay = 4;
        resp_q = 8'h77;
        @(negedge clk);
        m1_a = 16'h0400; m1_d = 8'h41; m1_rw = 1'b0;
        m1_req = ~m1_req;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m1_a = 16'hFFFF; m1_d = 8'h00; m1_rw = 1'b1;
        wait_log(base + 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wr_timeout log=%0d exp=%0d", ack_log.size(), base + 1); end
        checks++; if (dma_a !== 16'h0400) begin failures++; $display("FAIL wr_dma_a got=%h exp=0400", dma_a); end
        checks++; if (dma_d !== 8'h41) begin failures++; $display("FAIL wr_dma_d got=%h exp=41", dma_d); end
        checks++; if (dma_rw !== 1'b0) begin failures++; $display("FAIL wr_dma_rw got=%b exp=0", dma_rw); end
        checks++; if (m1_q !== 8'h5A) begin failures++; $display("FAIL wr_m1_q got=%h exp=5a", m1_q); end
        checks++; if (m1_ack !== 1'b1) begin failures++; $display("FAIL wr_m1_ack got=%b exp=1", m1_ack); end
        m1_rw = 1'b1;
    endtask

    task automatic test_reset_mid_wait;
        int base;
        bit ok;
        resp_en = 0;
        @(negedge clk);
        m0_a = 16'hBEEF;
        m0_req = ~m0_req;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        #1;
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin failures++; $display("FAIL midrst_acks got=%b%b exp=00", m0_ack, m1_ack); end
        checks++; if (dma_req !== 1'b0) begin failures++; $display("FAIL midrst_dma_req got=%b exp=0", dma_req); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        base = ack_log.size();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dma_req !== dma_ack) begin failures++; $display("FAIL midrst_sync got=%b exp=%b", dma_req, dma_ack); end
        resp_en = 1;
        resp_delay = 0;
        repeat (8) @(posedge clk);
        #2;
        checks++; if (ack_log.size() != base) begin failures++; $display("FAIL midrst_dropped got=%0d exp=0", ack_log.size() - base); end
        // arbitration history restarts: m0 takes the first tie again
        @(negedge clk);
        m0_req = ~m0_req;
        m1_req = ~m1_req;
        wait_log(base + 2, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout log=%0d exp=%0d", ack_log.size() - base, 2); end
        else begin
            checks++; if (ack_log[base] != 0 || ack_log[base + 1] != 1) begin
                failures++; $display("FAIL midrst_order got=m%0d,m%0d exp=m0,m1", ack_log[base], ack_log[base + 1]);
            end
        end
    endtask

`ifdef DMA_ARB_LOCK_EN
    task automatic test_lock;
        int base;
        bit ok;
        base = ack_log.size();
        resp_delay = 1;
        @(negedge clk);
        m0_lock = 1'b1;
        m0_req = ~m0_req;
        @(negedge clk);
        m1_req = ~m1_req;
        wait_log(base + 1, ok);
        @(negedge clk);
        m0_req = ~m0_req;
        wait_log(base + 2, ok);
        @(negedge clk);
        m0_lock = 1'b0;
        m0_req = ~m0_req;
        wait_log(base + 4, ok);
        checks++; if (!ok) begin failures++; $display("FAIL lock_timeout log=%0d exp=4", ack_log.size() - base); end
        else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (ack_log[base + k] != (k == 3 ? 1 : 0)) begin
                    failures++; $display("FAIL lock_order slot=%0d got=m%0d exp=m%0d", k, ack_log[base + k], (k == 3 ? 1 : 0));
                end
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        m0_a = '0; m0_d = '0; m0_rw = 1'b1; m0_req = 1'b0;
        m1_a = '0; m1_d = '0; m1_rw = 1'b1; m1_req = 1'b0;
`ifdef DMA_ARB_LOCK_EN
        m0_lock = 1'b0; m1_lock = 1'b0;
`endif
        dma_q = 8'h00;
        dma_ack = 1'b0;
        test_reset();
        test_round_robin();
        test_read();
        test_latency();
        test_write_stable();
        test_reset_mid_wait();
`ifdef DMA_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
